counter_ctrl: RTL and testbench

Sequencing controller for the programmable wrap counter datapath. Owns the count register, holds the initial/wrap configuration, and starts, stops and optionally pauses counting. Counts a programmed number of wrap ticks before signalling completion. Sits between a host/FSM issuing commands and any logic consuming `q_o`/`tick_o`, such as display dividers and timers.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_ctrl_adder.sv | 20 ++
 rtl/counter_ctrl.sv | 112 +++++++++++
 tb/tb_counter_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter_ctrl slice.
package counter_pkg;

  localparam int unsigned NBITS_DEF = 16;
  localparam int unsigned RBITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/counter_ctrl_adder.sv
// Next-value/tick block: increments a and reloads ini when a+1 hits wrap.
module adder #(
  parameter int unsigned NBITS = 16
) (
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] ini,
  input  logic [NBITS-1:0] wrap,
  output logic [NBITS-1:0] nextq,
  output logic             tick
);

  logic [NBITS-1:0] inc;

  always_comb begin
    inc   = a + NBITS'(1);
    tick  = (inc == wrap);
    nextq = tick ? ini : inc;
  end

endmodule

// File: rtl/counter_ctrl.sv
// Programmable wrap counter sequencer; pause support with COUNTER_CTRL_PAUSE_EN.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned RBITS = RBITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [NBITS-1:0] cfg_ini,
  input  logic [NBITS-1:0] cfg_rst,
  input  logic [RBITS-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
`ifdef COUNTER_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic [NBITS-1:0] q_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             cfg_err_o,
  output logic [RBITS-1:0] reps_left_o
);

  state_t           state;
  logic [NBITS-1:0] ini_r;
  logic [NBITS-1:0] rst_r;
  logic [RBITS-1:0] reps_r;
  logic [NBITS-1:0] nextq;
  logic             wrap_tick;
  logic             pause_hold;

`ifdef COUNTER_CTRL_PAUSE_EN
  assign pause_hold = pause;
`else
  assign pause_hold = 1'b0;
`endif

  adder #(.NBITS(NBITS)) u_adder (
    .a     (q_o),
    .ini   (ini_r),
    .wrap  (rst_r),
    .nextq (nextq),
    .tick  (wrap_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_o         <= '0;
      reps_left_o <= '0;
      ini_r       <= '0;
      rst_r       <= '0;
      reps_r      <= '0;
      tick_o      <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
      cfg_err_o   <= 1'b0;
    end else begin
      tick_o    <= 1'b0;
      done_o    <= 1'b0;
      cfg_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) begin
            ini_r  <= cfg_ini;
            rst_r  <= cfg_rst;
            reps_r <= cfg_reps;
          end
          // A same-cycle cfg_we bypasses straight into the start load.
          if (start && !stop) begin
            q_o         <= cfg_we ? cfg_ini : ini_r;
            reps_left_o <= cfg_we ? cfg_reps : reps_r;
            state       <= RUN;
            busy_o      <= 1'b1;
          end
        end
        RUN, PAUSE: begin
          cfg_err_o <= cfg_we;
          if (stop) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (pause_hold) begin
            state <= PAUSE;
          end else begin
            // Releasing from PAUSE counts on the same edge, so the tick phase is unchanged.
            q_o   <= nextq;
            state <= RUN;
            if (wrap_tick) begin
              tick_o <= 1'b1;
              if (reps_r != '0) begin
                reps_left_o <= reps_left_o - RBITS'(1);
                if (reps_left_o == RBITS'(1)) begin
                  done_o <= 1'b1;
                  state  <= IDLE;
                  busy_o <= 1'b0;
                end
              end
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl; pause steps run only with COUNTER_CTRL_PAUSE_EN.
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, start, stop, pause;
  logic [15:0] cfg_ini, cfg_rst;
  logic [7:0]  cfg_reps;
  logic [15:0] q_o;
  logic        tick_o, done_o, busy_o, cfg_err_o;
  logic [7:0]  reps_left_o;

  logic        s_cfg_we, s_start, s_stop;
  logic [3:0]  s_cfg_ini, s_cfg_rst;
  logic [7:0]  s_cfg_reps;
  logic [3:0]  s_q;
  logic        s_tick, s_done, s_busy, s_err;
  logic [7:0]  s_reps_left;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  counter_ctrl u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ini     (cfg_ini),
    .cfg_rst     (cfg_rst),
    .cfg_reps    (cfg_reps),
    .start       (start),
    .stop        (stop),
`ifdef COUNTER_CTRL_PAUSE_EN
    .pause       (pause),
`endif
    .q_o         (q_o),
    .tick_o      (tick_o),
    .done_o      (done_o),
    .busy_o      (busy_o),
    .cfg_err_o   (cfg_err_o),
    .reps_left_o (reps_left_o)
  );

  counter_ctrl #(.NBITS(4), .RBITS(8)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (s_cfg_we),
    .cfg_ini     (s_cfg_ini),
    .cfg_rst     (s_cfg_rst),
    .cfg_reps    (s_cfg_reps),
    .start       (s_start),
    .stop        (s_stop),
`ifdef COUNTER_CTRL_PAUSE_EN
    .pause       (1'b0),
`endif
    .q_o         (s_q),
    .tick_o      (s_tick),
    .done_o      (s_done),
    .busy_o      (s_busy),
    .cfg_err_o   (s_err),
    .reps_left_o (s_reps_left)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs q/tick/done/busy of the 16-bit instance for compact sequence checks.
  task automatic check_main(input string tag, input logic [15:0] eq, input logic et,
                            input logic ed, input logic eb);
    check({tag, ".q"},    32'(q_o),    32'(eq));
    check({tag, ".tick"}, 32'(tick_o), 32'(et));
    check({tag, ".done"}, 32'(done_o), 32'(ed));
    check({tag, ".busy"}, 32'(busy_o), 32'(eb));
  endtask

  initial begin
    logic [15:0] basic_q [8];
    logic        basic_t [8];
    logic [3:0]  wrap_q  [4];
    basic_q = '{16'd4, 16'd5, 16'd6, 16'd3, 16'd4, 16'd5, 16'd6, 16'd3};
    basic_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    wrap_q  = '{4'd15, 4'd0, 4'd1, 4'd14};

    rst_n = 1'b0; cfg_we = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    cfg_ini = '0; cfg_rst = '0; cfg_reps = '0;
    s_cfg_we = 1'b0; s_start = 1'b0; s_stop = 1'b0;
    s_cfg_ini = '0; s_cfg_rst = '0; s_cfg_reps = '0;
    step(); step();
    check_main("reset", 16'd0, 1'b0, 1'b0, 1'b0);
    check("reset.err",  32'(cfg_err_o),   32'd0);
    check("reset.reps", 32'(reps_left_o), 32'd0);
    rst_n = 1'b1;

    // Basic count with config and start on the same cycle.
    cfg_we = 1'b1; cfg_ini = 16'd3; cfg_rst = 16'd7; cfg_reps = 8'd2; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    check_main("basic.start", 16'd3, 1'b0, 1'b0, 1'b1);
    check("basic.reps0", 32'(reps_left_o), 32'd2);
    for (int i = 0; i < 8; i++) begin
      step();
      check_main($sformatf("basic[%0d]", i), basic_q[i], basic_t[i], i == 7, i != 7);
      if (i == 3) check("basic.reps1", 32'(reps_left_o), 32'd1);
    end
    check("basic.reps_end", 32'(reps_left_o), 32'd0);
    step();
    check_main("basic.idle", 16'd3, 1'b0, 1'b0, 1'b0);

    // Free-run with a tick every cycle, then stop.
    cfg_we = 1'b1; cfg_ini = 16'd0; cfg_rst = 16'd1; cfg_reps = 8'd0;
    step();
    cfg_we = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check_main("free.start", 16'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      check_main($sformatf("free[%0d]", i), 16'd0, 1'b1, 1'b0, 1'b1);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_main("free.stop", 16'd0, 1'b0, 1'b0, 1'b0);

    // Illegal config write during a run.
    cfg_we = 1'b1; cfg_ini = 16'd3; cfg_rst = 16'd7; cfg_reps = 8'd0; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    check_main("ill.start", 16'd3, 1'b0, 1'b0, 1'b1);
    cfg_we = 1'b1; cfg_ini = 16'd9; cfg_rst = 16'd12;
    step();
    cfg_we = 1'b0;
    check_main("ill.q4", 16'd4, 1'b0, 1'b0, 1'b1);
    check("ill.err", 32'(cfg_err_o), 32'd1);
    step();
    check("ill.err_pulse", 32'(cfg_err_o), 32'd0);
    check_main("ill.q5", 16'd5, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_main("ill.q6", 16'd6, 1'b0, 1'b0, 1'b1);
    step();
    check_main("ill.wrap", 16'd3, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    step();
    check_main("ill.stop", 16'd3, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_main("startstop", 16'd3, 1'b0, 1'b0, 1'b0);

    // Wrap-around through all-ones on the 4-bit instance.
    s_cfg_we = 1'b1; s_cfg_ini = 4'd14; s_cfg_rst = 4'd2; s_start = 1'b1;
    step();
    s_cfg_we = 1'b0; s_start = 1'b0;
    check("wrap.start", 32'(s_q), 32'd14);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wrap.q[%0d]", i),    32'(s_q),    32'(wrap_q[i]));
      check($sformatf("wrap.tick[%0d]", i), 32'(s_tick), 32'(i == 3));
    end

`ifdef COUNTER_CTRL_PAUSE_EN
    cfg_we = 1'b1; cfg_ini = 16'd3; cfg_rst = 16'd7; cfg_reps = 8'd0; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    step(); step();
    check_main("pause.pre", 16'd5, 1'b0, 1'b0, 1'b1);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_main($sformatf("pause[%0d]", i), 16'd5, 1'b0, 1'b0, 1'b1);
    end
    pause = 1'b0;
    step();
    check_main("pause.rel", 16'd6, 1'b0, 1'b0, 1'b1);
    step();
    check_main("pause.wrap", 16'd3, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
`endif

    // Reset mid-run clears config; next start runs from zero.
    cfg_we = 1'b1; cfg_ini = 16'd3; cfg_rst = 16'd7; cfg_reps = 8'd2; start = 1'b1;
    step();
    cfg_we = 1'b0; start = 1'b0;
    step();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_main("rst.run", 16'd0, 1'b0, 1'b0, 1'b0);
    check("rst.reps", 32'(reps_left_o), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check_main("rst.start", 16'd0, 1'b0, 1'b0, 1'b1);
    check("rst.reps_cfg", 32'(reps_left_o), 32'd0);
    step();
    check_main("rst.count", 16'd1, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
